fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter STARTING_ADDR, default 32'h01000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entry count (fixed at 2 for this revision).
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port fetch_enable  input  1  permits IDLE->FETCH and continued fetching.
REQ-006 SHALL have port mem_address  output  32  word address to main memory; equals fetch_pc.
REQ-007 SHALL have port mem_read_write  output  1  memory direction; constant 0 (READ).
REQ-008 SHALL have port mem_data_in  output  32  memory write data; constant 32'h0.
REQ-009 SHALL have port mem_data_out  input  32  little-endian instruction word from memory, valid combinationally for mem_address.
REQ-010 SHALL have port inst_valid  output  1  buffer head holds an instruction.
REQ-011 SHALL have port inst_ready  input  1  consumer accepts the head this cycle.
REQ-012 SHALL have port inst  output  32  instruction at buffer head.
REQ-013 SHALL have port inst_pc  output  32  address of the head instruction.
REQ-014 SHALL have port redirect_valid  input  1  request to restart fetch at redirect_pc.
REQ-015 SHALL have port redirect_pc  input  32  new fetch address.
REQ-016 SHALL have port misaligned  output  1  sticky error flag for a non-word-aligned redirect.

Function
REQ-017 SHALL implement states IDLE, FETCH and ERROR, held in a registered state variable.
REQ-018 SHALL transition IDLE->FETCH on a rising edge with fetch_enable=1, and FETCH->IDLE with fetch_enable=0 and no redirect; the buffer contents are retained in IDLE.
REQ-019 SHALL push in FETCH when count<2 or a pop occurs in the same cycle: {mem_data_out, fetch_pc} is written and fetch_pc += 4.
REQ-020 SHALL pop when inst_valid=1 and inst_ready=1; inst/inst_pc then show the next entry, or inst_valid=0 if the buffer is empty.
REQ-021 SHALL, with count=2 and no pop, neither push nor advance fetch_pc; mem_address stays stable.
REQ-022 SHALL give one-cycle latency: a word fetched at edge N appears on inst from edge N, so inst_valid=1 in cycle N+1 when the buffer was empty.
REQ-023 SHALL never present a combinational path from mem_data_out to inst; inst, inst_pc and inst_valid are register outputs only.
REQ-024 SHALL wrap fetch_pc modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000, with no flag raised.
REQ-025 SHALL, on redirect_valid=1 with redirect_pc[1:0]=0 in IDLE or FETCH, flush the buffer (count=0) and set fetch_pc=redirect_pc; no push occurs that cycle.
REQ-026 SHALL give redirect priority over a simultaneous push and pop; the popped instruction is still considered consumed.
REQ-027 SHALL, on redirect_valid=1 with redirect_pc[1:0]!=0, flush the buffer, enter ERROR and set misaligned=1; fetch_pc is unchanged.
REQ-028 SHALL in ERROR hold inst_valid=0, never push, ignore redirect and fetch_enable, and remain there until reset_n is asserted.
REQ-029 SHALL drive mem_read_write=0 and mem_data_in=0 in every state.

Reset
REQ-030 SHALL, on reset_n=0 and regardless of clock, immediately set state=IDLE, fetch_pc=STARTING_ADDR, count=0, inst_valid=0, inst=0, inst_pc=0 and misaligned=0.
REQ-031 SHALL drop any in-flight fetch on reset asserted mid-FETCH, and resume at STARTING_ADDR after reset_n=1 and fetch_enable=1.

Verification
REQ-032 Scenario: reset, then fetch_enable=1 with memory words W0,W1,W2 at 0x01000000.. and inst_ready=1 -> inst_pc sequence 0x01000000, 0x01000004, 0x01000008, one instruction per cycle, inst equal to W0,W1,W2.
REQ-033 Scenario: inst_ready=0 for 5 cycles -> count saturates at 2, mem_address frozen at 0x01000008, head holds W0; on release, W0,W1,W2 are delivered without loss or duplication.
REQ-034 Scenario: redirect_pc=0x01000100 in the same cycle as a pop -> buffer flushed, next inst_pc=0x01000100, no pre-redirect instruction appears after the redirect.
REQ-035 Scenario: redirect_pc=0x01000102 -> misaligned=1 and inst_valid=0 indefinitely, and a later aligned redirect is ignored until reset.
REQ-036 Scenario: redirect to 0xFFFFFFF8, consuming 3 instructions -> inst_pc values 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-037 Scenario: reset_n pulsed low between clock edges while count=2 -> outputs clear immediately and the first post-reset inst_pc is 0x01000000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads sequential words from main memory into a
// two-entry instruction buffer and presents the buffer head to a consumer
// through a valid/ready handshake. Supports redirects; a misaligned redirect
// parks the unit in a sticky ERROR state until reset.
//
// Ports
//   clock, reset_n        : clock, asynchronous active-low reset
//   fetch_enable          : allow fetching (IDLE->FETCH, stay in FETCH)
//   mem_address           : word address to memory (current fetch_pc)
//   mem_read_write        : memory direction, always read (0)
//   mem_data_in           : memory write data, always 0
//   mem_data_out          : instruction word for mem_address (combinational)
//   inst_valid/inst_ready : buffer head handshake
//   inst, inst_pc         : buffer head instruction and its address
//   redirect_valid/_pc    : restart fetch at redirect_pc
//   misaligned            : sticky flag for a non-word-aligned redirect
module fetch_unit #(
    parameter logic [31:0] STARTING_ADDR = 32'h01000000,
    parameter int unsigned BUF_DEPTH     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_enable,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misaligned
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      head_inst_q, head_inst_d, head_pc_q, head_pc_d;
    logic [31:0]      tail_inst_q, tail_inst_d, tail_pc_q, tail_pc_d;
    logic             valid_q, valid_d;
    logic             misaligned_q, misaligned_d;
    logic             pop, push;

    assign mem_address    = fetch_pc_q;
    assign mem_read_write = 1'b0;
    assign mem_data_in    = 32'h0;
    assign inst_valid     = valid_q;
    assign inst           = head_inst_q;
    assign inst_pc        = head_pc_q;
    assign misaligned     = misaligned_q;

    // State and buffer registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= STARTING_ADDR;
            count_q      <= '0;
            head_inst_q  <= 32'h0;
            head_pc_q    <= 32'h0;
            tail_inst_q  <= 32'h0;
            tail_pc_q    <= 32'h0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            count_q      <= count_d;
            head_inst_q  <= head_inst_d;
            head_pc_q    <= head_pc_d;
            tail_inst_q  <= tail_inst_d;
            tail_pc_q    <= tail_pc_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Next-state, buffer and fetch-pc update
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        count_d      = count_q;
        head_inst_d  = head_inst_q;
        head_pc_d    = head_pc_q;
        tail_inst_d  = tail_inst_q;
        tail_pc_d    = tail_pc_q;
        valid_d      = valid_q;
        misaligned_d = misaligned_q;
        pop          = valid_q && inst_ready;
        push         = 1'b0;

        case (state_q)
            ERROR: ;
            default: begin
                if (redirect_valid) begin
                    // Redirect wins over any push; a same-cycle pop is still consumed.
                    count_d = '0;
                    valid_d = 1'b0;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_d      = ERROR;
                        misaligned_d = 1'b1;
                    end else begin
                        fetch_pc_d = redirect_pc;
                        if (state_q == IDLE && fetch_enable) state_d = FETCH;
                    end
                end else begin
                    push = (state_q == FETCH) &&
                           ((count_q < CNT_W'(BUF_DEPTH)) || pop);
                    if (push) fetch_pc_d = fetch_pc_q + 32'd4;

                    case (count_q)
                        2'd0: begin
                            if (push) begin
                                head_inst_d = mem_data_out;
                                head_pc_d   = fetch_pc_q;
                                count_d     = 2'd1;
                            end
                        end
                        2'd1: begin
                            if (pop && push) begin
                                head_inst_d = mem_data_out;
                                head_pc_d   = fetch_pc_q;
                            end else if (pop) begin
                                count_d = 2'd0;
                            end else if (push) begin
                                tail_inst_d = mem_data_out;
                                tail_pc_d   = fetch_pc_q;
                                count_d     = 2'd2;
                            end
                        end
                        2'd2: begin
                            // Full: a push is only possible alongside a pop.
                            if (pop) begin
                                head_inst_d = tail_inst_q;
                                head_pc_d   = tail_pc_q;
                                if (push) begin
                                    tail_inst_d = mem_data_out;
                                    tail_pc_d   = fetch_pc_q;
                                end else begin
                                    count_d = 2'd1;
                                end
                            end
                        end
                        default: ;
                    endcase
                    valid_d = (count_d != 2'd0);

                    if (state_q == IDLE && fetch_enable)       state_d = FETCH;
                    else if (state_q == FETCH && !fetch_enable) state_d = IDLE;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// enable/ready/redirect/reset traffic, compared against a queue-based model.
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h01000000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    // Reference model: fetch mode (0 idle, 1 fetch, 2 error), pc, buffer queues
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] q_inst[$];
    logic [31:0] q_pc[$];

    fetch_unit #(.STARTING_ADDR(START), .BUF_DEPTH(2)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .fetch_enable   (fetch_enable),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misaligned     (misaligned)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A1234;
    endfunction

    assign mem_data_out = mem_word(mem_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = START;
        m_mis  = 1'b0;
        q_inst.delete();
        q_pc.delete();
    endtask

    task automatic model_step(input logic en, input logic rdy, input logic rv,
                              input logic [31:0] rpc);
        bit pop;
        pop = (q_inst.size() > 0) && rdy;
        if (m_mode == 2) return;
        if (rv) begin
            q_inst.delete();
            q_pc.delete();
            if (rpc[1:0] != 2'b00) begin
                m_mode = 2;
                m_mis  = 1'b1;
            end else begin
                m_pc = rpc;
                if (m_mode == 0 && en) m_mode = 1;
            end
            return;
        end
        if (pop) begin
            void'(q_inst.pop_front());
            void'(q_pc.pop_front());
        end
        if (m_mode == 1 && q_inst.size() < 2) begin
            q_inst.push_back(mem_word(m_pc));
            q_pc.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (m_mode == 0 && en)       m_mode = 1;
        else if (m_mode == 1 && !en) m_mode = 0;
    endtask

    task automatic compare_all();
        check("inst_valid", 32'(inst_valid), 32'(q_inst.size() > 0));
        if (q_inst.size() > 0) begin
            check("inst", inst, q_inst[0]);
            check("inst_pc", inst_pc, q_pc[0]);
        end
        check("mem_address", mem_address, m_pc);
        check("misaligned", 32'(misaligned), 32'(m_mis));
        check("mem_read_write", 32'(mem_read_write), 32'h0);
        check("mem_data_in", mem_data_in, 32'h0);
    endtask

    // One clock: drive inputs, advance the model, sample #1 after the edge
    task automatic cycle(input logic en, input logic rdy, input logic rv,
                         input logic [31:0] rpc);
        fetch_enable   = en;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(en, rdy, rv, rpc);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once
    task automatic reset_pulse();
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_inst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_mem_address", mem_address, START);
        check("rst_misaligned", 32'(misaligned), 32'h0);
        model_reset();
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic        en_r, rdy_r, rv_r;
        logic [31:0] rpc_r;

        reset_n        = 1'b0;
        fetch_enable   = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_valid", 32'(inst_valid), 32'h0);
        check("reset_inst", inst, 32'h0);
        check("reset_pc", inst_pc, 32'h0);
        check("reset_addr", mem_address, START);
        reset_n = 1'b1;

        // Sequential stream with consumer always ready
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Back-pressure: buffer fills, address freezes, then drains in order
        reset_pulse();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("frozen_addr", mem_address, 32'h01000008);
        check("held_head", inst, mem_word(START));
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Redirect coincident with a pop
        cycle(1'b1, 1'b1, 1'b1, 32'h01000100);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Wrap of the fetch address
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFFFFF8);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Misaligned redirect, later aligned redirect ignored
        cycle(1'b1, 1'b1, 1'b1, 32'h01000102);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h01000200);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Reset while the buffer is full, then restart from the start address
        reset_pulse();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        reset_pulse();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            en_r  = ($urandom_range(0, 9) != 0);
            rdy_r = ($urandom_range(0, 9) < 6);
            rv_r  = ($urandom_range(0, 29) == 0);
            rpc_r = $urandom;
            rpc_r[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) rpc_r = 32'hFFFFFFF0;
            if ($urandom_range(0, 4) == 0) rpc_r[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 79) == 0) reset_pulse();
            else cycle(en_r, rdy_r, rv_r, rpc_r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
